// File: rtl/mul_div_pkg.sv
// Shared types for the MUL/DIV arbiter: request/response payloads, opcodes and FSM states.
package mul_div_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TRX_W = 4;
  localparam int unsigned TAG_W = 5;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [XLEN-1:0]  src0;
    logic [XLEN-1:0]  src1;
    logic [TRX_W-1:0] trx_id;
    logic [TAG_W-1:0] rd0_tag;
  } req_struct;

  typedef struct packed {
    logic [XLEN-1:0]  rd0_wdata;
    logic [TRX_W-1:0] trx_id;
    logic [TAG_W-1:0] rd0_tag;
  } resp_struct;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

endpackage

// File: rtl/mul_div_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((32'(ptr_i) + off) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/mul_div_arbiter.sv
// Shares one MUL/DIV unit among NUM_REQ requesters: round-robin accept, single op in
// flight, response buffered and returned to its owner under req/ack.
module mul_div_arbiter
  import mul_div_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       m_req_i,
  input  req_struct [NUM_REQ-1:0]  m_rdata_bi,
  output logic [NUM_REQ-1:0]       m_ack_o,
  output logic [NUM_REQ-1:0]       m_resp_req_o,
  output resp_struct               m_resp_wdata_bo,
  input  logic [NUM_REQ-1:0]       m_resp_ack_i,
  output logic                     exu_req_o,
  output req_struct                exu_rdata_bo,
  input  logic                     exu_ack_i,
  input  logic                     exu_resp_req_i,
  input  resp_struct               exu_resp_wdata_bi,
  output logic                     exu_resp_ack_o,
  output logic                     busy_o,
  output logic                     err_timeout_o,
  output logic                     err_spurious_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 8;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  req_struct        req_buf_q, req_buf_d;
  resp_struct       resp_buf_q, resp_buf_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_tmo_q, err_tmo_d;
  logic             err_spur_q, err_spur_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i   (m_req_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .valid_o (grant_vld)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      req_buf_q  <= '0;
      resp_buf_q <= '0;
      tmo_cnt_q  <= '0;
      err_tmo_q  <= 1'b0;
      err_spur_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      req_buf_q  <= req_buf_d;
      resp_buf_q <= resp_buf_d;
      tmo_cnt_q  <= tmo_cnt_d;
      err_tmo_q  <= err_tmo_d;
      err_spur_q <= err_spur_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    req_buf_d    = req_buf_q;
    resp_buf_d   = resp_buf_q;
    tmo_cnt_d    = tmo_cnt_q;
    err_tmo_d    = err_tmo_q;
    err_spur_d   = err_spur_q;
    m_ack_o      = '0;
    m_resp_req_o = '0;
    exu_req_o    = 1'b0;

    // A response pulse is only meaningful while an op is outstanding.
    if (exu_resp_req_i && (state_q != ARB_WAIT)) begin
      err_spur_d = 1'b1;
    end

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_vld) begin
          m_ack_o   = grant;
          req_buf_d = m_rdata_bi[grant_idx];
          owner_d   = grant_idx;
          state_d   = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        exu_req_o = 1'b1;
        if (exu_ack_i) begin
          tmo_cnt_d = '0;
          state_d   = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (tmo_cnt_q != CNT_W'(TIMEOUT_CYC)) begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
        if (tmo_cnt_d == CNT_W'(TIMEOUT_CYC)) begin
          err_tmo_d = 1'b1;
        end
        if (exu_resp_req_i) begin
          resp_buf_d = exu_resp_wdata_bi;
          state_d    = ARB_RESP;
        end
      end
      ARB_RESP: begin
        m_resp_req_o[owner_q] = 1'b1;
        if (m_resp_ack_i[owner_q]) begin
          rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign exu_rdata_bo    = req_buf_q;
  assign m_resp_wdata_bo = resp_buf_q;
  assign exu_resp_ack_o  = 1'b1;
  assign busy_o          = (state_q != ARB_IDLE);
  assign err_timeout_o   = err_tmo_q;
  assign err_spurious_o  = err_spur_q;

endmodule
